pwm_capture: RTL
================

// Module: pwm_capture
//
// PURPOSE
//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform.
//  Reports period and high time in clk cycles, plus a one-cycle valid strobe per completed period.
//  Flags a stalled input (0% or 100% duty, or disconnected) after a programmable timeout.
//  Sits between a board-level PWM pin or on-chip PWM out and a register or control block.
//
// PARAMETERS
//  W        32     width of period/high_time counters and outputs
//  TIMEOUT  1000   cycles without a rising edge before stalled asserts; must be 2..2^W-1
//  FILT_LEN 4      consecutive equal samples needed to accept a level (filter build only)
//
// PORTS
//  clk        in   1  system clock; all logic rising-edge
//  rst        in   1  asynchronous, active-high reset
//  pwm_in     in   1  PWM input, asynchronous to clk
//  period     out  W  cycles between last two accepted rising edges
//  high_time  out  W  cycles input was high within that period
//  valid      out  1  1-cycle pulse when period/high_time update
//  stalled    out  1  level: no rising edge for TIMEOUT cycles
//  level      out  1  current accepted (synchronised/filtered) input level
//
// BEHAVIOUR
//  - Reset: period=0, high_time=0, valid=0, stalled=0, level=0, sync flops=0, state=IDLE.
//    Async assert at any time aborts the measurement in progress; restart from IDLE.
//  - Input path: 2-flop synchroniser, then edge-detect register. Rise/fall is seen 3 cycles after the pin edge.
//  - Counters: per_cnt and hi_cnt, W bits each. TIMEOUT <= 2^W-1 guarantees they never wrap.
//  - FSM states IDLE, HIGH, LOW:
//      IDLE -> HIGH on rise: per_cnt=1, hi_cnt=1; no valid, since the first period is incomplete.
//      HIGH: per_cnt++, hi_cnt++. On fall -> LOW; hi_cnt holds.
//      LOW: per_cnt++. On rise: period<=per_cnt, high_time<=hi_cnt, valid=1 next cycle;
//        per_cnt=1, hi_cnt=1 -> HIGH.
//  - The edge cycle itself counts as 1. A 10-cycle PWM with 3 high cycles reports period=10, high_time=3.
//  - Timeout: if per_cnt reaches TIMEOUT in HIGH or LOW, or TIMEOUT cycles pass in IDLE:
//      stalled<=1 and state -> IDLE.
//      period/high_time keep their last values; valid stays 0.
//  - stalled clears on the next accepted rising edge. A fresh full period is needed before the next valid.
//  - A rise in the same cycle as timeout wins: it is a normal edge and stalled does not assert.
//  - level always mirrors the accepted input, including while stalled.
//    Software tells 0% from 100% duty by reading it.
//  - Latency: valid is high 1 cycle after the accepted rise that closes a period.
//
// CONFIGURATION
//  PWM_CAPTURE_GLITCH_FILTER_EN
//    defined:
//      - after the synchroniser, a level is accepted only after FILT_LEN consecutive equal samples.
//      - pulses shorter than FILT_LEN cycles are ignored.
//      - edge latency becomes 3+FILT_LEN cycles.
//      - period is unchanged for a clean input; high_time is unchanged because both edges are delayed equally.
//    undefined: the synchronised input feeds edge-detect directly; FILT_LEN is unused.
//
// STRUCTURE
//  Package pwm_capture_pkg: state enum {IDLE, HIGH, LOW}, SYNC_STAGES=2 constant.
//  Sub-module pwm_capture_sync: synchroniser, optional filter, edge detect.
//    Outputs lvl, rise, fall.
//  Top holds the FSM, counters, timeout compare and output registers.
//
// TESTING
//  1 Reset released, pwm 10-cycle period, 3 high: first valid on the 2nd rise; period=10, high_time=3 every period after.
//  2 Duty change 3->7 mid-stream: next complete period reports high_time=7, period=10; no spurious valid.
//  3 pwm held high, TIMEOUT=50: stalled=1 exactly 50 cycles after the last rise, level=1, valid=0.
//    A rise after release clears stalled.
//  4 pwm held low from reset, TIMEOUT=50: stalled=1 after 50 cycles, level=0, period=high_time=0.
//  5 rst pulsed mid-HIGH: all outputs 0 immediately. The next valid comes only after two fresh rises.
//  6 Filter build, FILT_LEN=4: 2-cycle glitch in the low phase -> ignored, period=10 unchanged.
//    Non-filter build: same glitch -> valid with period<10.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared types and constants for the PWM capture block.
// Holds the measurement FSM state encoding and synchroniser depth.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: input synchroniser, optional glitch filter, edge detect.
// Glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture_sync
   import pwm_capture_pkg::*;
#(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   acc;

   if (FILT_LEN < 1) begin : g_filt_len_check
      $error("FILT_LEN must be at least 1");
   end

   // bring the asynchronous pin into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int CW = $clog2(FILT_LEN + 1);

   logic [CW-1:0] cnt;
   logic          filt;

   // accept a new level only after FILT_LEN consecutive differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (sync[SYNC_STAGES-1] == filt) begin
         cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
         cnt  <= '0;
         filt <= sync[SYNC_STAGES-1];
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign acc = filt;
`else
   assign acc = sync[SYNC_STAGES-1];
`endif

   // register the accepted level and its edges together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         lvl  <= acc;
         rise <= acc & ~lvl;
         fall <= ~acc & lvl;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM signal.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to filter short input pulses.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int W        = 32,
   parameter int TIMEOUT  = 1000,
   parameter int FILT_LEN = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pwm_in,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         valid,
   output logic         stalled,
   output logic         level
);

   localparam logic [W-1:0] TO_CNT   = W'(TIMEOUT);
   localparam logic [W-1:0] TO_IDLE  = W'(TIMEOUT - 1);
   localparam logic [W-1:0] ONE      = W'(1);

   state_t       state;
   logic [W-1:0] per_cnt;
   logic [W-1:0] hi_cnt;
   logic         rise;
   logic         fall;

   pwm_capture_sync #(
      .FILT_LEN (FILT_LEN)
   ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .lvl    (level),
      .rise   (rise),
      .fall   (fall)
   );

   // measurement FSM: count period and high time, publish on closing rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         per_cnt   <= '0;
         hi_cnt    <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         stalled   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (rise) begin
            if (state == LOW) begin
               period    <= per_cnt;
               high_time <= hi_cnt;
               valid     <= 1'b1;
            end
            per_cnt <= ONE;
            hi_cnt  <= ONE;
            stalled <= 1'b0;
            state   <= HIGH;
         end else begin
            unique case (state)
               IDLE: begin
                  if (!stalled) begin
                     if (per_cnt == TO_IDLE) begin
                        stalled <= 1'b1;
                        per_cnt <= '0;
                     end else begin
                        per_cnt <= per_cnt + 1'b1;
                     end
                  end
               end
               HIGH: begin
                  if (per_cnt == TO_CNT) begin
                     stalled <= 1'b1;
                     per_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     per_cnt <= per_cnt + 1'b1;
                     if (fall) begin
                        state <= LOW;
                     end else begin
                        hi_cnt <= hi_cnt + 1'b1;
                     end
                  end
               end
               LOW: begin
                  if (per_cnt == TO_CNT) begin
                     stalled <= 1'b1;
                     per_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     per_cnt <= per_cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
